fcvt_w_s_pipe: RTL and testbench
================================

# fcvt_w_s_pipe

Pipelined single-precision float to 32-bit integer converter implementing RISC-V FCVT.W.S and FCVT.WU.S semantics, including all five rounding modes and the invalid/inexact exception flags. It is the inverse of the integer-to-float converter in the FP execute path. It accepts one operand per cycle through a valid/ready handshake, has a fixed two-stage pipeline with full backpressure, and returns the result plus flags to the FP writeback/CSR-flag logic.

## Interface
- F_WIDTH, 32, float operand width
- F_EXP, 8, exponent field width
- F_FLAC, 23, fraction field width
- I_WIDTH, 32, integer result width

- CLK  in  1  clock, all state on rising edge
- RST  in  1  asynchronous, active-high reset
- in_valid  in  1  operand present
- in_ready  out  1  converter accepts operand this cycle
- in1  in  F_WIDTH  IEEE-754 single operand
- rm  in  3  resolved rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101–111 treated as RTZ
- is_unsigned  in  1  1 = FCVT.WU.S, 0 = FCVT.W.S
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- out1  out  I_WIDTH  integer result
- invalid  out  1  NV flag for this result
- inexact  out  1  NX flag for this result

## Operation
- Transfer occurs when valid & ready on the same edge. Operands, rm and is_unsigned are sampled only on input transfer.
- Stage 1 (unpack/align):
  - Decode sign, exponent e = exp − 127, and mantissa m = {1, frac}.
  - Denormals use m = {0, frac} with e = −126.
  - Classify NaN (exp all-ones, frac ≠ 0), ±inf, zero, and huge (e ≥ 32).
  - For −1 ≤ e ≤ 31, shift m to a 32-bit integer magnitude plus guard bit plus sticky bit (OR of all lower bits).
  - For e < −1: magnitude 0, guard 0, sticky = (m ≠ 0). For e = −1: magnitude 0, guard 1, sticky = OR of frac.
- Stage 2 (round/saturate):
  - Round-up increment by mode:
    - RNE: g & (s | lsb)
    - RTZ: 0
    - RDN: sign & (g | s)
    - RUP: ~sign & (g | s)
    - RMM: g
  - Rounded magnitude is kept at 33 bits, so the carry is not lost.
  - Signed result = sign ? −mag : mag.
- Out-of-range handling (invalid = 1, inexact = 0):
  - Signed:
    - NaN, +inf, or positive mag > 2^31−1 → 0x7FFFFFFF.
    - −inf or negative mag > 2^31 → 0x80000000.
  - Unsigned:
    - NaN, +inf, or mag > 2^32−1 → 0xFFFFFFFF.
    - Negative with rounded mag ≠ 0, or −inf → 0x00000000.
- Otherwise invalid = 0 and inexact = g | s.
- Zero of either sign → 0, no flags. Negative inputs that round to 0 in unsigned mode → 0, inexact only.
- invalid and inexact are never both 1.

## Timing
- Latency: 2 cycles. An input transferred at edge N gives out_valid at edge N+2 when there is no stall.
- Throughput: 1 per cycle while out_ready = 1.
- Stage advance rules:
  - s2_load = s1_valid & (~s2_valid | out_ready)
  - in_ready = ~s1_valid | s2_load
- in_ready is combinational from out_ready and internal valids only. It has no dependence on in_valid.
- While out_valid & ~out_ready, out1, invalid and inexact hold stable.
- Results are delivered strictly in input order, with no loss or duplication.
- With both stages full and out_ready = 0, in_ready = 0. If out_ready rises in the same cycle as a new in_valid, the pipe shifts and accepts the new operand in that cycle.
- Reset (asserted any time, including mid-flight): s1_valid = s2_valid = 0 and out_valid = 0 immediately. in_ready = 1 after reset. out1 = 0, invalid = 0, inexact = 0. In-flight operations are discarded.
- Data registers update only on stage load, to minimise toggling.

## Test plan
- Rounding:
  - 0x3FC00000 (1.5), signed: RNE → 2 NX; RTZ → 1 NX; RDN → 1 NX; RUP → 2 NX; RMM → 2 NX.
  - 0x40200000 (2.5): RNE → 2 NX; RMM → 3 NX.
  - 0xBFC00000 (−1.5): RDN → 0xFFFFFFFE NX.
- Boundaries:
  - 0xCF000000 signed → 0x80000000, no flags.
  - 0x4F000000 signed → 0x7FFFFFFF NV; unsigned → 0x80000000, no flags.
  - 0x4F800000 unsigned → 0xFFFFFFFF NV.
- Specials:
  - 0x7FC00000: signed → 0x7FFFFFFF NV; unsigned → 0xFFFFFFFF NV.
  - 0xFF800000: signed → 0x80000000 NV; unsigned → 0 NV.
  - 0x80000000 → 0, no flags.
  - 0x00000001 RUP → 1 NX.
- Unsigned negatives:
  - 0xBF000000 (−0.5): RTZ → 0 NX only; RDN → 0 NV only.
- Backpressure: 6 back-to-back operands with out_ready low for cycles 3–5.
  - in_ready drops once both stages are full.
  - All 6 results emerge in order, each stable while stalled; no drops or duplicates.
- Reset: assert RST with both stages valid.
  - out_valid = 0 and outputs = 0 immediately; in_ready = 1.
  - After release, the next operand produces a correct result at 2-cycle latency.

Source files
------------

// File: rtl/fcvt_w_s_pipe.sv
// rtl/fcvt_w_s_pipe.sv - pipelined single-precision float to 32-bit integer converter (FCVT.W.S / FCVT.WU.S)
//
// Purpose: two-stage converter with valid/ready handshake and full backpressure.
//   Stage 1 unpacks and aligns the operand into integer magnitude + guard + sticky.
//   Stage 2 rounds, saturates and raises NV/NX; it is also the output register.
// Ports:
//   CLK, RST            clock, asynchronous active-high reset
//   in_valid/in_ready   operand handshake; in1, rm, is_unsigned sampled on transfer
//   out_valid/out_ready result handshake; out1, invalid, inexact held while stalled
module fcvt_w_s_pipe #(
  parameter int F_WIDTH = 32,
  parameter int F_EXP   = 8,
  parameter int F_FLAC  = 23,
  parameter int I_WIDTH = 32
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [F_WIDTH-1:0] in1,
  input  logic [2:0]         rm,
  input  logic               is_unsigned,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [I_WIDTH-1:0] out1,
  output logic               invalid,
  output logic               inexact
);

  // Pipeline control
  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  logic s2_load, in_fire;

  assign s2_load    = s1_valid_q & (~s2_valid_q | out_ready);
  assign in_ready   = ~s1_valid_q | s2_load;
  assign in_fire    = in_valid & in_ready;
  assign s1_valid_d = in_fire | (s1_valid_q & ~s2_load);
  assign s2_valid_d = s2_load | (s2_valid_q & ~out_ready);
  assign out_valid  = s2_valid_q;

  // Stage 1: unpack / align
  logic [F_EXP-1:0]  exp_fld;
  logic [F_FLAC-1:0] frac_fld;
  logic [F_FLAC:0]   m_w;
  logic signed [9:0] e_w, e_p1;
  logic [55:0]       x_w;
  logic              sign_d, nan_d, inf_d, huge_d, g_d, s_d;
  logic [31:0]       mag_d;

  assign sign_d   = in1[F_WIDTH-1];
  assign exp_fld  = in1[F_WIDTH-2 -: F_EXP];
  assign frac_fld = in1[F_FLAC-1:0];
  // Hidden bit is set for every non-zero exponent; denormals keep it clear.
  assign m_w      = {|exp_fld, frac_fld};
  assign e_w      = (exp_fld == '0) ? -10'sd126 : ($signed(10'(exp_fld)) - 10'sd127);
  assign e_p1     = e_w + 10'sd1;
  assign nan_d    = (&exp_fld) & (|frac_fld);
  assign inf_d    = (&exp_fld) & ~(|frac_fld);
  assign huge_d   = (e_w >= 10'sd32);

  // x_w bit i weighs 2^(i-24): [55:24] integer part, [23] guard, [22:0] sticky source.
  // Shifting m (weight 2^(e-23)) left by e+1 places it there for -1 <= e <= 31.
  always_comb begin
    x_w   = '0;
    mag_d = '0;
    g_d   = 1'b0;
    s_d   = 1'b0;
    if (e_w >= -10'sd1 && e_w <= 10'sd31) begin
      x_w   = 56'(m_w) << $unsigned(e_p1);
      mag_d = x_w[55:24];
      g_d   = x_w[23];
      s_d   = |x_w[22:0];
    end else if (e_w < -10'sd1) begin
      s_d = |m_w;
    end
  end

  logic        s1_sign_q, s1_nan_q, s1_inf_q, s1_huge_q, s1_g_q, s1_s_q, s1_uns_q;
  logic [31:0] s1_mag_q;
  logic [2:0]  s1_rm_q;

  // Stage 2: round / saturate
  logic        inc;
  logic [32:0] rmag;
  logic        big;
  logic [I_WIDTH-1:0] res_d;
  logic        nv_d, nx_d;

  always_comb begin
    inc = 1'b0;
    case (s1_rm_q)
      3'b000:  inc = s1_g_q & (s1_s_q | s1_mag_q[0]);
      3'b010:  inc = s1_sign_q & (s1_g_q | s1_s_q);
      3'b011:  inc = ~s1_sign_q & (s1_g_q | s1_s_q);
      3'b100:  inc = s1_g_q;
      default: inc = 1'b0;  // RTZ and reserved encodings
    endcase
  end

  // 33 bits so a carry out of 0xFFFFFFFF is seen as overflow.
  assign rmag = {1'b0, s1_mag_q} + {32'd0, inc};
  assign big  = s1_huge_q | s1_inf_q;

  always_comb begin
    res_d = '0;
    nv_d  = 1'b0;
    nx_d  = s1_g_q | s1_s_q;
    if (s1_uns_q) begin
      if (s1_nan_q | (~s1_sign_q & (big | rmag[32]))) begin
        res_d = 32'hFFFF_FFFF;
        nv_d  = 1'b1;
        nx_d  = 1'b0;
      end else if (s1_sign_q & (big | (rmag != 33'd0))) begin
        res_d = 32'h0000_0000;
        nv_d  = 1'b1;
        nx_d  = 1'b0;
      end else begin
        res_d = rmag[31:0];
      end
    end else begin
      if (s1_nan_q | (~s1_sign_q & (big | (rmag > 33'h0_7FFF_FFFF)))) begin
        res_d = 32'h7FFF_FFFF;
        nv_d  = 1'b1;
        nx_d  = 1'b0;
      end else if (s1_sign_q & (big | (rmag > 33'h0_8000_0000))) begin
        res_d = 32'h8000_0000;
        nv_d  = 1'b1;
        nx_d  = 1'b0;
      end else begin
        res_d = s1_sign_q ? (~rmag[31:0] + 32'd1) : rmag[31:0];
      end
    end
  end

  logic [I_WIDTH-1:0] out1_q;
  logic               invalid_q, inexact_q;

  assign out1    = out1_q;
  assign invalid = invalid_q;
  assign inexact = inexact_q;

  // Data registers only move on stage load; valids move every cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_nan_q   <= 1'b0;
      s1_inf_q   <= 1'b0;
      s1_huge_q  <= 1'b0;
      s1_g_q     <= 1'b0;
      s1_s_q     <= 1'b0;
      s1_uns_q   <= 1'b0;
      s1_mag_q   <= '0;
      s1_rm_q    <= '0;
      out1_q     <= '0;
      invalid_q  <= 1'b0;
      inexact_q  <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      if (in_fire) begin
        s1_sign_q <= sign_d;
        s1_nan_q  <= nan_d;
        s1_inf_q  <= inf_d;
        s1_huge_q <= huge_d;
        s1_g_q    <= g_d;
        s1_s_q    <= s_d;
        s1_uns_q  <= is_unsigned;
        s1_mag_q  <= mag_d;
        s1_rm_q   <= rm;
      end
      if (s2_load) begin
        out1_q    <= res_d;
        invalid_q <= nv_d;
        inexact_q <= nx_d;
      end
    end
  end

endmodule

// File: tb/tb_fcvt_w_s_pipe.sv
// tb/tb_fcvt_w_s_pipe.sv - directed scoreboard bench for fcvt_w_s_pipe
module tb_fcvt_w_s_pipe;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in1 = 32'h0;
  logic [2:0]  rm = 3'd0;
  logic        is_unsigned = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out1;
  logic        invalid;
  logic        inexact;

  localparam logic [2:0] RNE = 3'd0, RTZ = 3'd1, RDN = 3'd2, RUP = 3'd3, RMM = 3'd4;

  int total = 0;
  int bad   = 0;
  logic [33:0] exp_q[$];
  bit          saw_block = 1'b0;
  bit          stalled = 1'b0;
  logic [33:0] held = '0;

  fcvt_w_s_pipe dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .rm(rm), .is_unsigned(is_unsigned),
    .out_valid(out_valid), .out_ready(out_ready),
    .out1(out1), .invalid(invalid), .inexact(inexact)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic send(input logic [31:0] f, input logic [2:0] r, input logic u,
                      input logic [31:0] ev, input logic nv, input logic nx);
    int budget;
    budget = 0;
    in1 = f; rm = r; is_unsigned = u; in_valid = 1'b1;
    #1;
    while (!in_ready && budget < 50) begin
      saw_block = 1'b1;
      @(negedge CLK); #1;
      budget++;
    end
    chk("send_accept", {33'd0, in_ready}, 34'd1);
    exp_q.push_back({ev, nv, nx});
    @(posedge CLK);
    @(negedge CLK);
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 100) begin
      @(negedge CLK);
      budget++;
    end
    @(negedge CLK);
    chk(tag, 34'(exp_q.size()), 34'd0);
  endtask

  // Output monitor / scoreboard
  always @(negedge CLK) begin
    logic [33:0] got;
    #2;
    got = {out1, invalid, inexact};
    if (!RST && out_valid && out_ready) begin
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL extra_output observed=%h expected=none", got);
      end
      if (exp_q.size() != 0) chk("result", got, exp_q.pop_front());
    end
    if (!RST && out_valid && !out_ready) begin
      if (stalled) chk("stall_hold", got, held);
      held    = got;
      stalled = 1'b1;
    end else begin
      stalled = 1'b0;
    end
  end

  initial begin
    // Reset state
    @(negedge CLK); #1;
    chk("reset_outputs", {out1, invalid, inexact}, 34'd0);
    chk("reset_out_valid", {33'd0, out_valid}, 34'd0);
    chk("reset_in_ready", {33'd0, in_ready}, 34'd1);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    // Latency: transfer at edge N, output valid after edge N+1 (taken at N+2)
    send(32'h3FC00000, RNE, 1'b0, 32'd2, 1'b0, 1'b1);
    chk("lat_first_cycle", {33'd0, out_valid}, 34'd0);
    @(negedge CLK);
    chk("lat_second_cycle", {33'd0, out_valid}, 34'd1);
    @(negedge CLK);

    // Rounding modes
    send(32'h3FC00000, RTZ, 1'b0, 32'd1, 1'b0, 1'b1);
    send(32'h3FC00000, RDN, 1'b0, 32'd1, 1'b0, 1'b1);
    send(32'h3FC00000, RUP, 1'b0, 32'd2, 1'b0, 1'b1);
    send(32'h3FC00000, RMM, 1'b0, 32'd2, 1'b0, 1'b1);
    send(32'h3FC00000, 3'd5, 1'b0, 32'd1, 1'b0, 1'b1);
    send(32'h40200000, RNE, 1'b0, 32'd2, 1'b0, 1'b1);
    send(32'h40200000, RMM, 1'b0, 32'd3, 1'b0, 1'b1);
    send(32'h3F000000, RNE, 1'b0, 32'd0, 1'b0, 1'b1);
    send(32'hBFC00000, RDN, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b1);
    // Boundaries
    send(32'hCF000000, RNE, 1'b0, 32'h80000000, 1'b0, 1'b0);
    send(32'h4F000000, RNE, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0);
    send(32'h4F000000, RNE, 1'b1, 32'h80000000, 1'b0, 1'b0);
    send(32'h4F800000, RNE, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
    send(32'h4F7FFFFF, RNE, 1'b1, 32'hFFFFFF00, 1'b0, 1'b0);
    send(32'h4F7FFFFF, RNE, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0);
    // Specials
    send(32'h7FC00000, RNE, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0);
    send(32'h7FC00000, RNE, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
    send(32'hFF800000, RNE, 1'b0, 32'h80000000, 1'b1, 1'b0);
    send(32'hFF800000, RNE, 1'b1, 32'h00000000, 1'b1, 1'b0);
    send(32'h80000000, RNE, 1'b0, 32'h00000000, 1'b0, 1'b0);
    send(32'h80000000, RNE, 1'b1, 32'h00000000, 1'b0, 1'b0);
    send(32'h00000001, RUP, 1'b0, 32'd1, 1'b0, 1'b1);
    // Unsigned negatives
    send(32'hBF000000, RTZ, 1'b1, 32'd0, 1'b0, 1'b1);
    send(32'hBF000000, RDN, 1'b1, 32'd0, 1'b1, 1'b0);
    drain("drain_directed");

    // Backpressure: six back-to-back operands, out_ready low for three cycles
    saw_block = 1'b0;
    fork
      begin
        repeat (2) @(negedge CLK);
        out_ready = 1'b0;
        repeat (3) @(negedge CLK);
        out_ready = 1'b1;
      end
      begin
        send(32'h3F800000, RTZ, 1'b0, 32'd1, 1'b0, 1'b0);
        send(32'h40000000, RTZ, 1'b0, 32'd2, 1'b0, 1'b0);
        send(32'h40400000, RTZ, 1'b0, 32'd3, 1'b0, 1'b0);
        send(32'h40800000, RTZ, 1'b0, 32'd4, 1'b0, 1'b0);
        send(32'h40A00000, RTZ, 1'b0, 32'd5, 1'b0, 1'b0);
        send(32'h40C00000, RTZ, 1'b0, 32'd6, 1'b0, 1'b0);
      end
    join
    chk("bp_in_ready_dropped", {33'd0, saw_block}, 34'd1);
    drain("drain_backpressure");

    // Reset with both stages full
    out_ready = 1'b0;
    send(32'h40400000, RTZ, 1'b0, 32'd3, 1'b0, 1'b0);
    send(32'h40800000, RTZ, 1'b0, 32'd4, 1'b0, 1'b0);
    #1;
    chk("full_in_ready", {33'd0, in_ready}, 34'd0);
    chk("full_out_valid", {33'd0, out_valid}, 34'd1);
    @(posedge CLK);
    #2;
    RST = 1'b1;
    #1;
    chk("midreset_out_valid", {33'd0, out_valid}, 34'd0);
    chk("midreset_outputs", {out1, invalid, inexact}, 34'd0);
    chk("midreset_in_ready", {33'd0, in_ready}, 34'd1);
    exp_q.delete();
    @(negedge CLK);
    RST = 1'b0;
    out_ready = 1'b1;
    @(negedge CLK);
    send(32'h40200000, RMM, 1'b0, 32'd3, 1'b0, 1'b1);
    chk("post_reset_lat1", {33'd0, out_valid}, 34'd0);
    @(negedge CLK);
    chk("post_reset_lat2", {33'd0, out_valid}, 34'd1);
    drain("drain_post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
